osd_cmd_tx: RTL and testbench

//  Initiator side of the OSD I/O command bus (io_osd/io_strobe/io_din) consumed by the OSD overlay.

---
 rtl/osd_cmd_tx_if.sv | 32 +++
 rtl/osd_cmd_tx.sv | 159 +++++++++++++++
 tb/tb_osd_cmd_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_cmd_tx_if.sv
// Command and OSD I/O bus bundle for osd_cmd_tx.
// master = on-core controller / OSD receiver side, slave = osd_cmd_tx.
interface osd_cmd_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_line;
  logic [12:0] cmd_len;
  logic [11:0] info_x;
  logic [11:0] info_y;
  logic [5:0]  info_w;
  logic [5:0]  info_h;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;

  modport master (
    output cmd_valid, cmd_op, cmd_line, cmd_len, info_x, info_y, info_w, info_h,
           wr_data, wr_valid,
    input  cmd_ready, wr_ready, busy, io_osd, io_strobe, io_din
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_line, cmd_len, info_x, info_y, info_w, info_h,
           wr_data, wr_valid,
    output cmd_ready, wr_ready, busy, io_osd, io_strobe, io_din
  );
endinterface

// File: rtl/osd_cmd_tx.sv
// OSD I/O command bus initiator: frames commands into strobed 16-bit words on io_osd/io_strobe/io_din.
// Optional OSD_TX_BURST_EN: write length taken from cmd_len (clamped to end of buffer) instead of 256.
module osd_cmd_tx #(
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2,
  parameter int GAP       = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  osd_cmd_tx_if.slave   bus
);

  localparam int TW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LO,
    S_HI,
    S_NEXT,
    S_END
  } state_t;

  state_t      state;
  logic [TW-1:0] tmr;
  logic [12:0] rem;
  logic        is_write;
  logic [11:0] x_q;
  logic [11:0] y_q;
  logic [5:0]  w_q;
  logic [5:0]  h_q;

  logic [15:0] cmd_word;
  logic [15:0] param_word;
  logic [12:0] wr_len;

`ifdef OSD_TX_BURST_EN
  // Receiver address wraps at 4096; room left from the start line is (16 - line[3:0]) * 256 bytes.
  logic [12:0] room;
  assign room   = {5'd16 - {1'b0, bus.cmd_line[3:0]}, 8'h00};
  assign wr_len = (bus.cmd_len < room) ? bus.cmd_len : room;
`else
  assign wr_len = 13'd256;
`endif

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cmd_word = 16'h0020 | {11'h000, bus.cmd_line};
    case (bus.cmd_op)
      2'd0:    cmd_word = 16'h0040;
      2'd1:    cmd_word = 16'h0041;
      2'd2:    cmd_word = 16'h0045;
      default: cmd_word = 16'h0020 | {11'h000, bus.cmd_line};
    endcase
  end

  // Info parameters go out in the order x, y, w, h as rem counts 4 -> 1.
  always_comb begin
    param_word = {10'h000, h_q};
    case (rem[2:0])
      3'd4:    param_word = {4'h0, x_q};
      3'd3:    param_word = {4'h0, y_q};
      3'd2:    param_word = {10'h000, w_q};
      default: param_word = {10'h000, h_q};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      tmr           <= '0;
      rem           <= '0;
      is_write      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.wr_ready  <= 1'b0;
      bus.io_osd    <= 1'b0;
      bus.io_strobe <= 1'b0;
      bus.io_din    <= '0;
    end else begin
      bus.wr_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            x_q           <= bus.info_x;
            y_q           <= bus.info_y;
            w_q           <= bus.info_w;
            h_q           <= bus.info_h;
            is_write      <= (bus.cmd_op == 2'd3);
            rem           <= (bus.cmd_op == 2'd3) ? wr_len :
                             (bus.cmd_op == 2'd2) ? 13'd4 : 13'd0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            bus.io_osd    <= 1'b1;
            bus.io_din    <= cmd_word;
            state         <= S_SETUP;
          end
        end
        S_SETUP: begin
          tmr   <= '0;
          state <= S_LO;
        end
        S_LO: begin
          if (tmr == TW'(STROBE_LO - 1)) begin
            tmr           <= '0;
            bus.io_strobe <= 1'b1;
            state         <= S_HI;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_HI: begin
          if (tmr == TW'(STROBE_HI - 1)) begin
            tmr           <= '0;
            bus.io_strobe <= 1'b0;
            state         <= S_NEXT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_NEXT: begin
          tmr <= '0;
          if (rem == 13'd0) begin
            bus.io_osd <= 1'b0;
            bus.io_din <= '0;
            state      <= S_END;
          end else if (!is_write) begin
            bus.io_din <= param_word;
            rem        <= rem - 1'b1;
            state      <= S_LO;
          end else if (bus.wr_valid) begin
            // Stalls here with strobe low and frame held until the producer has a byte.
            bus.io_din   <= {8'h00, bus.wr_data};
            bus.wr_ready <= 1'b1;
            rem          <= rem - 1'b1;
            state        <= S_LO;
          end
        end
        S_END: begin
          if (tmr == TW'(GAP - 1)) begin
            tmr           <= '0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Randomized scoreboard bench for osd_cmd_tx: stimulus pushes expected words, a monitor pops on each
// io_strobe rising edge and also checks strobe widths, data stability, frame gaps and wr_ready pulses.
module tb_osd_cmd_tx;
  localparam int STROBE_HI = 2;
  localparam int STROBE_LO = 2;
  localparam int GAP       = 4;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  osd_cmd_tx_if bus ();

  osd_cmd_tx #(.STROBE_HI(STROBE_HI), .STROBE_LO(STROBE_LO), .GAP(GAP)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_ready_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference: number of write payload bytes the receiver should get.
  function automatic int model_len(input int line, input int len);
`ifdef OSD_TX_BURST_EN
    int room;
    room = 4096 - ((line * 256) % 4096);
    return (len < room) ? len : room;
`else
    return 256;
`endif
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    logic        p_osd, p_strobe;
    logic [15:0] p_din;
    int          hi_cnt, lo_cnt, gap_cnt;
    bit          gap_valid;
    p_osd = 0; p_strobe = 0; p_din = '0;
    hi_cnt = 0; lo_cnt = 0; gap_cnt = 0; gap_valid = 0;
    forever begin
      @(negedge clk_sys);
      if (reset !== 1'b0) begin
        p_osd = 0; p_strobe = 0; p_din = '0;
        hi_cnt = 0; lo_cnt = 0; gap_cnt = 0; gap_valid = 0;
        continue;
      end
      if (bus.wr_ready) wr_ready_cnt++;
      if (bus.io_osd && !p_osd) begin
        if (gap_valid) check("gap_width_ge", 32'(gap_cnt >= GAP), 1);
        lo_cnt = 0;
      end
      if (!bus.io_osd && p_osd) begin
        check("frame_words_left", exp_q.size(), 0);
        gap_cnt   = 0;
        gap_valid = 1;
      end
      if (!bus.io_osd) gap_cnt++;
      if (bus.io_strobe && !p_strobe) begin
        check("strobe_in_frame", bus.io_osd, 1);
        check("din_before_rise", bus.io_din, p_din);
        check("strobe_lo_width_ge", 32'(lo_cnt >= STROBE_LO), 1);
        check("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("word", bus.io_din, exp_q.pop_front());
        hi_cnt = 0;
        lo_cnt = 0;
      end
      if (bus.io_strobe && p_strobe) check("din_hold", bus.io_din, p_din);
      if (!bus.io_strobe && p_strobe) check("strobe_hi_width", hi_cnt, STROBE_HI);
      if (bus.io_strobe) hi_cnt++;
      if (bus.io_osd && !bus.io_strobe) lo_cnt++;
      p_osd    = bus.io_osd;
      p_strobe = bus.io_strobe;
      p_din    = bus.io_din;
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    check(name, bus.cmd_ready, 1);
  endtask

  task automatic scramble();
    bus.cmd_op   = 2'($urandom);
    bus.cmd_line = 5'($urandom);
    bus.cmd_len  = 13'($urandom);
    bus.info_x   = 12'($urandom);
    bus.info_y   = 12'($urandom);
    bus.info_w   = 6'($urandom);
    bus.info_h   = 6'($urandom);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] line, input logic [12:0] len,
                          input logic [11:0] x, input logic [11:0] y,
                          input logic [5:0] w, input logic [5:0] h, input logic [7:0] payload[$]);
    int c;
    bus.cmd_op = op; bus.cmd_line = line; bus.cmd_len = len;
    bus.info_x = x; bus.info_y = y; bus.info_w = w; bus.info_h = h;
    bus.cmd_valid = 1'b1;
    wait_ready("cmd_ready_wait");
    case (op)
      2'd0: exp_q.push_back(16'h0040);
      2'd1: exp_q.push_back(16'h0041);
      2'd2: begin
        exp_q.push_back(16'h0045);
        exp_q.push_back(16'(x));
        exp_q.push_back(16'(y));
        exp_q.push_back(16'(w));
        exp_q.push_back(16'(h));
      end
      default: begin
        exp_q.push_back(16'h0020 + 16'(line));
        foreach (payload[i]) exp_q.push_back(16'(payload[i]));
      end
    endcase
    tick();
    bus.cmd_valid = 1'b0;
    scramble();
    check("cmd_ready_after_accept", bus.cmd_ready, 0);
    check("busy_after_accept", bus.busy, 1);
    c = 0;
    while (!bus.io_strobe && c < 50) begin
      tick();
      c++;
    end
    check("first_strobe_latency", c, STROBE_LO + 1);
  endtask

  task automatic feed(input logic [7:0] bytes[$], input int gap, input bit rand_gap);
    int n;
    foreach (bytes[i]) begin
      bus.wr_data  = bytes[i];
      bus.wr_valid = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus.wr_ready && n < 2000);
      check("wr_ready_seen", bus.wr_ready, 1);
      bus.wr_valid = 1'b0;
      bus.wr_data  = 8'($urandom);
      repeat (rand_gap ? $urandom_range(0, gap) : gap) tick();
    end
  endtask

  task automatic run_write(input logic [4:0] line, input logic [12:0] len, input bit incr,
                           input int gap, input bit rand_gap);
    logic [7:0] b[$];
    int n, base;
    n = model_len(int'(line), int'(len));
    for (int i = 0; i < n; i++) b.push_back(incr ? 8'(i) : 8'($urandom));
    base = wr_ready_cnt;
    send_cmd(2'd3, line, len, 12'($urandom), 12'($urandom), 6'($urandom), 6'($urandom), b);
    feed(b, gap, rand_gap);
    wait_ready("write_done");
    tick();
    check("wr_ready_pulses", wr_ready_cnt - base, n);
  endtask

  task automatic run_simple(input logic [1:0] op, input logic [11:0] x, input logic [11:0] y,
                            input logic [5:0] w, input logic [5:0] h);
    logic [7:0] none[$];
    send_cmd(op, 5'($urandom), 13'($urandom), x, y, w, h, none);
  endtask

  initial begin
    logic [7:0] b[$];
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    scramble();
    #3 reset = 1'b1;
    #2;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_io_osd", bus.io_osd, 0);
    check("rst_io_strobe", bus.io_strobe, 0);
    check("rst_io_din", bus.io_din, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    run_simple(2'd0, '0, '0, '0, '0);
    wait_ready("disable_done");
    run_simple(2'd1, '0, '0, '0, '0);
    wait_ready("enable_done");
    run_simple(2'd2, 12'h123, 12'h045, 6'h20, 6'h08);
    wait_ready("info_done");
    repeat (3) begin
      run_simple(2'd2, 12'($urandom), 12'($urandom), 6'($urandom), 6'($urandom));
      wait_ready("info_rand_done");
    end

    run_write(5'd5, 13'd0, 1'b1, 7, 1'b0);
    run_write(5'd30, 13'd1000, 1'b0, 0, 1'b0);
    repeat (3) run_write(5'($urandom), 13'($urandom_range(0, 300)), 1'b0, 3, 1'b1);

    // Back-to-back: the second request is held until the first frame's gap has elapsed.
    run_simple(2'd0, '0, '0, '0, '0);
    run_simple(2'd1, '0, '0, '0, '0);
    wait_ready("back_to_back_done");

    // Abort a write after ten bytes with an asynchronous reset between clock edges.
    for (int i = 0; i < 256; i++) b.push_back(8'($urandom));
    send_cmd(2'd3, 5'd2, 13'd256, '0, '0, '0, '0, b);
    feed(b[0:9], 0, 1'b0);
    tick();
    #1 reset = 1'b1;
    #1;
    check("abort_io_osd", bus.io_osd, 0);
    check("abort_io_strobe", bus.io_strobe, 0);
    check("abort_io_din", bus.io_din, 0);
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_busy", bus.busy, 0);
    repeat (4) tick();
    check("abort_no_frame", bus.io_osd, 0);

    run_simple(2'd2, 12'hABC, 12'h0DE, 6'h3F, 6'h01);
    wait_ready("post_reset_done");
    repeat (6) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
